// File: rtl/hd_memory_reader.sv
// Read-side sequencer for the HD-Memory: fetches one hypervector row and streams it
// out as WORD_WIDTH words, either a single selected word (WordMode) or the whole row (RowMode).
module hd_memory_reader #(
  parameter int DIMENSION  = 512,
  parameter int WORD_WIDTH = 32,
  parameter int NR_ROWS    = 16,
  localparam int NW      = DIMENSION / WORD_WIDTH,
  localparam int ROW_AW  = $clog2(NR_ROWS),
  localparam int WORD_AW = $clog2(NW)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_mode_i,
  input  logic [ROW_AW-1:0]     cmd_row_addr_i,
  input  logic [WORD_AW-1:0]    cmd_word_addr_i,
  output logic                  mem_req_o,
  output logic [ROW_AW-1:0]     mem_row_addr_o,
  input  logic [DIMENSION-1:0]  mem_rdata_i,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic [WORD_WIDTH-1:0] word_data_o,
  output logic                  word_last_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    STREAM  = 2'd3
  } stateT;

  localparam logic [WORD_AW-1:0] LAST_IDX = WORD_AW'(NW - 1);

  stateT                             stateR;
  logic                              modeR;
  logic [WORD_AW-1:0]                idxR;
  logic [NW-1:0][WORD_WIDTH-1:0]     rowBufR;
  logic [NW-1:0][WORD_WIDTH-1:0]     rdataWords;
  logic [WORD_AW-1:0]                nextIdx;

  // Word 0 occupies the least-significant bits of the row.
  assign rdataWords = mem_rdata_i;
  assign nextIdx    = idxR + WORD_AW'(1);

  // Sequencer FSM; every output is a register so consumers see glitch-free, state-aligned values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stateR         <= IDLE;
      modeR          <= 1'b0;
      idxR           <= '0;
      rowBufR        <= '0;
      cmd_ready_o    <= 1'b1;
      mem_req_o      <= 1'b0;
      mem_row_addr_o <= '0;
      word_valid_o   <= 1'b0;
      word_data_o    <= '0;
      word_last_o    <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      case (stateR)
        IDLE: begin
          if (cmd_valid_i) begin
            modeR          <= cmd_mode_i;
            mem_row_addr_o <= cmd_row_addr_i;
            idxR           <= cmd_mode_i ? '0 : cmd_word_addr_i;
            mem_req_o      <= 1'b1;
            cmd_ready_o    <= 1'b0;
            busy_o         <= 1'b1;
            stateR         <= FETCH;
          end
        end
        FETCH: begin
          mem_req_o <= 1'b0;
          stateR    <= CAPTURE;
        end
        CAPTURE: begin
          // First beat comes straight from the read data so it is ready in the first STREAM cycle.
          rowBufR      <= rdataWords;
          word_data_o  <= rdataWords[idxR];
          word_last_o  <= !modeR || (idxR == LAST_IDX);
          word_valid_o <= 1'b1;
          stateR       <= STREAM;
        end
        STREAM: begin
          if (word_ready_i) begin
            if (word_last_o) begin
              word_valid_o <= 1'b0;
              word_last_o  <= 1'b0;
              cmd_ready_o  <= 1'b1;
              busy_o       <= 1'b0;
              stateR       <= IDLE;
            end else begin
              idxR        <= nextIdx;
              word_data_o <= rowBufR[nextIdx];
              word_last_o <= (nextIdx == LAST_IDX);
            end
          end
        end
        default: begin
          mem_req_o    <= 1'b0;
          word_valid_o <= 1'b0;
          word_last_o  <= 1'b0;
          cmd_ready_o  <= 1'b1;
          busy_o       <= 1'b0;
          stateR       <= IDLE;
        end
      endcase
    end
  end

endmodule
